backend_perf_counters: RTL and testbench

//  Per-core backend performance counter unit. Accumulates retire, decode, eligibility and issue

---
 rtl/backend_perf_counters.sv | 112 +++++++++++
 tb/tb_backend_perf_counters.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/backend_perf_counters.sv
// rtl/backend_perf_counters.sv - per-core backend perf counters with idle-timeout end-of-run detection
module backend_perf_counters #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_LANES     = 4,
  parameter int IDLE_TIMEOUT  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     retire_mask,
  input  logic                     decoded,
  input  logic                     eligible,
  input  logic                     issued,
  input  logic                     core_idle,
  output logic                     finished,
  output logic [COUNTER_WIDTH-1:0] perf_backend_instRetired,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cycles,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesDecoded,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesEligible,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesIssued
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int POP_W  = $clog2(NUM_LANES + 1);
  localparam logic [IDLE_W-1:0]        IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [IDLE_W-1:0]      idle_cnt_next;
  logic [POP_W-1:0]       retire_pop;
  logic [COUNTER_WIDTH:0] retire_sum;
  logic                   count_en;
  logic                   relaunch;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c,
                                                       input logic en);
    return (en && (c != CNT_MAX)) ? c + COUNTER_WIDTH'(1) : c;
  endfunction

  always_comb begin
    retire_pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      retire_pop = retire_pop + POP_W'(retire_mask[i]);
    end
  end

  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN: begin
        if (core_idle) begin
          state_next    = S_DRAIN;
          idle_cnt_next = '0;
        end
      end
      // idle_cnt counts DRAIN cycles already spent idle, so the RUN sample plus IDLE_TIMEOUT DRAIN samples end the run
      S_DRAIN: begin
        if (!core_idle)                 state_next    = S_RUN;
        else if (idle_cnt == IDLE_LAST) state_next    = S_DONE;
        else                            idle_cnt_next = idle_cnt + IDLE_W'(1);
      end
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  assign count_en   = (state == S_RUN) || (state == S_DRAIN);
  assign relaunch   = (state == S_DONE) && start;
  // One spare carry bit detects overflow of the multi-lane retire add
  assign retire_sum = {1'b0, perf_backend_instRetired} + (COUNTER_WIDTH + 1)'(retire_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state                       <= S_IDLE;
      idle_cnt                    <= '0;
      finished                    <= 1'b0;
      perf_backend_instRetired    <= '0;
      perf_backend_cycles         <= '0;
      perf_backend_cyclesDecoded  <= '0;
      perf_backend_cyclesEligible <= '0;
      perf_backend_cyclesIssued   <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      finished <= (state_next == S_DONE);
      if (relaunch) begin
        perf_backend_instRetired    <= '0;
        perf_backend_cycles         <= '0;
        perf_backend_cyclesDecoded  <= '0;
        perf_backend_cyclesEligible <= '0;
        perf_backend_cyclesIssued   <= '0;
      end else if (count_en) begin
        perf_backend_instRetired    <= retire_sum[COUNTER_WIDTH] ? CNT_MAX
                                                                 : retire_sum[COUNTER_WIDTH-1:0];
        perf_backend_cycles         <= sat_inc(perf_backend_cycles, 1'b1);
        perf_backend_cyclesDecoded  <= sat_inc(perf_backend_cyclesDecoded, decoded);
        perf_backend_cyclesEligible <= sat_inc(perf_backend_cyclesEligible, eligible);
        perf_backend_cyclesIssued   <= sat_inc(perf_backend_cyclesIssued, issued);
      end
    end
  end

endmodule

// File: tb/tb_backend_perf_counters.sv
// tb/tb_backend_perf_counters.sv - randomized model-checked bench for backend_perf_counters (64-bit and 8-bit instances)
module tb_backend_perf_counters;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] retire_mask = 4'd0;
  logic       decoded = 1'b0, eligible = 1'b0, issued = 1'b0, core_idle = 1'b0;

  logic        a_fin, b_fin;
  logic [63:0] a_ret, a_cyc, a_dec, a_elg, a_iss;
  logic [7:0]  b_ret, b_cyc, b_dec, b_elg, b_iss;

  int checks = 0;
  int errors = 0;

  // Model: run-length of consecutive idle samples while active; T+1 of them ends the run
  bit              m_active = 1'b0, m_done = 1'b0, cmp_en = 1'b0;
  int              m_idle_run = 0;
  longint unsigned m_ret = 0, m_cyc = 0, m_dec = 0, m_elg = 0, m_iss = 0;
  longint unsigned s_ret, s_cyc, s_dec, s_elg, s_iss;

  always #5 clock = ~clock;

  backend_perf_counters #(.COUNTER_WIDTH(64), .NUM_LANES(4), .IDLE_TIMEOUT(T)) dut_a (
    .clock(clock), .reset(reset), .start(start), .retire_mask(retire_mask),
    .decoded(decoded), .eligible(eligible), .issued(issued), .core_idle(core_idle),
    .finished(a_fin), .perf_backend_instRetired(a_ret), .perf_backend_cycles(a_cyc),
    .perf_backend_cyclesDecoded(a_dec), .perf_backend_cyclesEligible(a_elg),
    .perf_backend_cyclesIssued(a_iss));

  backend_perf_counters #(.COUNTER_WIDTH(8), .NUM_LANES(4), .IDLE_TIMEOUT(T)) dut_b (
    .clock(clock), .reset(reset), .start(start), .retire_mask(retire_mask),
    .decoded(decoded), .eligible(eligible), .issued(issued), .core_idle(core_idle),
    .finished(b_fin), .perf_backend_instRetired(b_ret), .perf_backend_cycles(b_cyc),
    .perf_backend_cyclesDecoded(b_dec), .perf_backend_cyclesEligible(b_elg),
    .perf_backend_cyclesIssued(b_iss));

  function automatic logic [63:0] sat8(input longint unsigned v);
    return (v > 64'd255) ? 64'd255 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    cmp_en <= 1'b1;
    if (reset) begin
      m_active <= 1'b0; m_done <= 1'b0; m_idle_run <= 0;
      m_ret <= 0; m_cyc <= 0; m_dec <= 0; m_elg <= 0; m_iss <= 0;
    end else if (m_done) begin
      if (start) begin
        m_done <= 1'b0; m_active <= 1'b1; m_idle_run <= 0;
        m_ret <= 0; m_cyc <= 0; m_dec <= 0; m_elg <= 0; m_iss <= 0;
      end
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_idle_run <= 0;
      end
    end else begin
      m_ret <= m_ret + 64'($countones(retire_mask));
      m_cyc <= m_cyc + 1;
      m_dec <= m_dec + 64'(decoded);
      m_elg <= m_elg + 64'(eligible);
      m_iss <= m_iss + 64'(issued);
      if (core_idle) begin
        m_idle_run <= m_idle_run + 1;
        if (m_idle_run + 1 == T + 1) begin
          m_active <= 1'b0; m_done <= 1'b1;
        end
      end else begin
        m_idle_run <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("a_finished", 64'(a_fin), 64'(m_done));
      chk("a_instRetired", a_ret, m_ret);
      chk("a_cycles", a_cyc, m_cyc);
      chk("a_cyclesDecoded", a_dec, m_dec);
      chk("a_cyclesEligible", a_elg, m_elg);
      chk("a_cyclesIssued", a_iss, m_iss);
      chk("b_finished", 64'(b_fin), 64'(m_done));
      chk("b_instRetired", 64'(b_ret), sat8(m_ret));
      chk("b_cycles", 64'(b_cyc), sat8(m_cyc));
      chk("b_cyclesDecoded", 64'(b_dec), sat8(m_dec));
      chk("b_cyclesEligible", 64'(b_elg), sat8(m_elg));
      chk("b_cyclesIssued", 64'(b_iss), sat8(m_iss));
    end
  end

  task automatic rnd_events();
    retire_mask = 4'($urandom);
    decoded     = 1'($urandom);
    eligible    = 1'($urandom);
    issued      = 1'($urandom);
  endtask

  initial begin
    int idle_pct;

    repeat (3) @(negedge clock);
    chk("reset_finished", 64'(a_fin), 64'd0);
    chk("reset_cycles", a_cyc, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_events(); core_idle = 1'($urandom);
      @(negedge clock);
    end
    chk("idle_no_count", a_cyc, 64'd0);

    // Basic counting, with a start pulse inside RUN that must be ignored
    retire_mask = 4'd0; decoded = 0; eligible = 0; issued = 0; core_idle = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    retire_mask = 4'b1011; decoded = 1'b1; issued = 1'b1; eligible = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      @(negedge clock);
    end
    start = 1'b0;
    chk("t1_instRetired", a_ret, 64'd30);
    chk("t1_cycles", a_cyc, 64'd10);
    chk("t1_cyclesDecoded", a_dec, 64'd10);
    chk("t1_cyclesIssued", a_iss, 64'd10);
    chk("t1_cyclesEligible", a_elg, 64'd0);
    chk("t1_finished", 64'(a_fin), 64'd0);
    chk("t1_model_ret", m_ret, 64'd30);

    // Interrupted idle period, then a full uninterrupted timeout
    core_idle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_events(); start = (i == 3);
      @(negedge clock);
    end
    core_idle = 1'b0; start = 1'b1; rnd_events();
    @(negedge clock);
    start = 1'b0; core_idle = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rnd_events();
      @(negedge clock);
      chk("t2_not_finished", 64'(a_fin), 64'd0);
    end
    rnd_events();
    @(negedge clock);
    chk("t2_finished", 64'(a_fin), 64'd1);
    chk("t2_model_done", 64'(m_done), 64'd1);

    // Events in DONE are dropped
    s_ret = m_ret; s_cyc = m_cyc; s_dec = m_dec; s_elg = m_elg; s_iss = m_iss;
    for (int i = 0; i < 20; i++) begin
      rnd_events(); core_idle = 1'($urandom);
      @(negedge clock);
    end
    chk("t4_hold_ret", a_ret, s_ret);
    chk("t4_hold_cyc", a_cyc, s_cyc);
    chk("t4_hold_dec", a_dec, s_dec);
    chk("t4_hold_elg", a_elg, s_elg);
    chk("t4_hold_iss", a_iss, s_iss);
    chk("t4_hold_fin", 64'(a_fin), 64'd1);
    start = 1'b1; rnd_events();
    @(negedge clock);
    start = 1'b0;
    chk("t4_clear_ret", a_ret, 64'd0);
    chk("t4_clear_cyc", a_cyc, 64'd0);
    chk("t4_clear_fin", 64'(a_fin), 64'd0);

    // Saturation of the 8-bit instance
    retire_mask = 4'hF; core_idle = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      if (i == 63) chk("t3_ret_63", 64'(b_ret), 64'd252);
      if (i >= 64) chk("t3_ret_sat", 64'(b_ret), 64'd255);
    end
    chk("t3_cycles", 64'(b_cyc), 64'd70);
    chk("t3_ret_wide", a_ret, 64'd280);

    // Reset in the middle of a run
    for (int i = 0; i < 5; i++) begin
      rnd_events();
      @(negedge clock);
    end
    reset = 1'b1; start = 1'b1; rnd_events();
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("t5_ret", a_ret, 64'd0);
    chk("t5_cyc", a_cyc, 64'd0);
    chk("t5_fin", 64'(a_fin), 64'd0);
    for (int i = 0; i < 8; i++) begin
      rnd_events(); core_idle = 1'($urandom);
      @(negedge clock);
    end
    chk("t5_idle_cyc", a_cyc, 64'd0);

    // Randomized traffic with varying idle density
    idle_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) idle_pct = (($urandom % 3) == 0) ? 5 : ((($urandom % 2) == 0) ? 60 : 99);
      rnd_events();
      core_idle = ($urandom_range(0, 99) < idle_pct);
      start     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
